aftab_branch_resolver: RTL and testbench
========================================

# aftab_branch_resolver

Multi-cycle branch/set-less-than resolver sitting directly downstream of the datapath comparator. On a start pulse from the controller it latches the operation, drives the comparator's signedness select, samples the lt/eq/gt flags, and produces a registered branch decision with target address, or an SLT/SLTU result word. Completion is reported with a one-cycle done pulse.

## Interface
- size, 32, datapath width (pc, imm, target, SLT result)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request from controller; sampled only in IDLE
- flush  input  1  synchronous abort; returns to IDLE, no done
- isBranch  input  1  1 = conditional branch, 0 = SLT/SLTU
- funct3  input  3  RV32I funct3 of the instruction
- pc  input  size  address of the branch instruction
- imm  input  size  sign-extended B-type offset
- lt, eq, gt  input  1 each  comparator flags
- comparedSignedUnsignedBar  output  1  signedness select to comparator
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion pulse
- branchTaken  output  1  branch condition true
- branchTarget  output  size  pc + imm
- misaligned  output  1  taken and branchTarget[1:0] != 0
- sltResult  output  size  zero-extended 0/1
- illegal  output  1  unsupported funct3 for the selected class

## Operation
- States: IDLE, CAPTURE, RESOLVE. Two-bit encoding from package.
- IDLE: start=1 latches isBranch, funct3, pc, imm → CAPTURE. start=0 stays.
- CAPTURE: comparator operands assumed stable; lt/eq/gt registered at the end of cycle → RESOLVE.
- RESOLVE: outputs computed from registered flags and latched operands, written to output registers; done=1 for the cycle after this edge; → IDLE.
- Signedness: driven combinationally from latched funct3. 0 for 110, 111, 011; 1 for all others, including BEQ/BNE.
- Branch conditions: 000 eq; 001 !eq; 100/110 lt; 101/111 gt|eq; 010/011 illegal.
- SLT class: 010 → lt (signed); 011 → lt (unsigned); any other funct3 is illegal.
- branchTarget = (pc + imm) mod 2^size; wrap-around is silent. It is computed for every branch, taken or not.
- misaligned only when branchTaken=1.
- Illegal op: done still pulses; branchTaken=0, misaligned=0, sltResult=0, illegal=1.
- Branch op: sltResult forced 0. SLT op: branchTaken=0, branchTarget=0, misaligned=0.
- Result outputs hold until the next RESOLVE. They are not cleared when done falls.
- start while busy: ignored; no queuing.
- flush in any state → IDLE next edge; result registers unchanged. Flush wins over start in IDLE.
- rst (async) at any time: state IDLE; all outputs 0 immediately. comparedSignedUnsignedBar resets to 1 because the latched funct3 resets to 000.

## Timing
- start sampled at edge E0. CAPTURE occupies E0–E1, with flags sampled at E1. Results registered at E2, and done is high during E2–E3.
- Start-to-done latency: 2 edges. Back-to-back ops: next start accepted at E3 at the earliest, since the block is in IDLE during E2–E3. Throughput is one op per 3 cycles.
- busy high from E0 to E2.
- Comparator path: latched operands → comparator → lt/eq/gt must settle within one cycle (CAPTURE).

## Structure
- Package aftab_branch_pkg:
  - funct3 constants BEQ, BNE, BLT, BGE, BLTU, BGEU, SLT, SLTU
  - state encoding IDLE=00, CAPTURE=01, RESOLVE=10
- Sub-module aftab_branch_cond_decode (combinational), mapping funct3, isBranch and flags to taken, sltBit, illegal and signedness.
- Adder and FSM stay in the top module.
- The comparator is instantiated by the datapath, not by this block.

## Test plan
- BEQ, flags eq=1, pc=0x100, imm=0x20, start at E0 → done at E2–E3; branchTaken=1, branchTarget=0x120, misaligned=0, busy high E0–E2.
- BLTU (110): comparedSignedUnsignedBar=0 during CAPTURE; flags lt=1 → taken. BGE (101) with gt=0, eq=0 → taken=0, target still pc+imm.
- SLTU (011), lt=1 → sltResult=0x00000001, branchTaken=0. Funct3 010 with isBranch=1 → illegal=1, done pulses.
- Taken branch with pc=0xFFFFFFF0, imm=0x12 → branchTarget=0x00000002 (wrap), misaligned=1.
- start in CAPTURE ignored. flush in CAPTURE → IDLE, no done, prior results held.
- rst asserted mid-RESOLVE (async, between edges) → busy, done and all results 0 immediately; next start completes normally.

Source files
------------

// File: rtl/aftab_branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aftab_branch_pkg
// Description : Shared funct3 codes and FSM state encoding for the branch /
//               set-less-than resolver.
// Revision    : 1.0 - initial release
// ============================================================================
package aftab_branch_pkg;

    // RV32I funct3 codes for conditional branches
    localparam logic [2:0] c_BEQ  = 3'b000;
    localparam logic [2:0] c_BNE  = 3'b001;
    localparam logic [2:0] c_BLT  = 3'b100;
    localparam logic [2:0] c_BGE  = 3'b101;
    localparam logic [2:0] c_BLTU = 3'b110;
    localparam logic [2:0] c_BGEU = 3'b111;

    // RV32I funct3 codes for set-less-than
    localparam logic [2:0] c_SLT  = 3'b010;
    localparam logic [2:0] c_SLTU = 3'b011;

    // Resolver FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        RESOLVE = 2'b10
    } state_t;

endpackage : aftab_branch_pkg
`default_nettype wire

// File: rtl/aftab_branch_cond_decode.sv
`default_nettype none
// ============================================================================
// Module      : aftab_branch_cond_decode
// Description : Combinational decode of funct3/class and comparator flags
//               into branch-taken, SLT bit, illegal flag and signedness.
// Revision    : 1.0 - initial release
// ============================================================================
module aftab_branch_cond_decode
    import aftab_branch_pkg::*;
(
    input  logic       isBranch_i,
    input  logic [2:0] funct3_i,
    input  logic       lt_i,
    input  logic       eq_i,
    input  logic       gt_i,
    output logic       taken_o,
    output logic       sltBit_o,
    output logic       illegal_o,
    output logic       signed_o
);

    // Condition selection; illegal encodings leave taken/sltBit low
    always_comb begin
        taken_o   = 1'b0;
        sltBit_o  = 1'b0;
        illegal_o = 1'b0;
        // Only the unsigned forms clear signedness; BEQ/BNE do not care but
        // still request a signed compare.
        signed_o  = !((funct3_i == c_BLTU) || (funct3_i == c_BGEU) ||
                      (funct3_i == c_SLTU));
        if (isBranch_i) begin
            case (funct3_i)
                c_BEQ:          taken_o   = eq_i;
                c_BNE:          taken_o   = !eq_i;
                c_BLT, c_BLTU:  taken_o   = lt_i;
                c_BGE, c_BGEU:  taken_o   = gt_i | eq_i;
                default:        illegal_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                c_SLT, c_SLTU:  sltBit_o  = lt_i;
                default:        illegal_o = 1'b1;
            endcase
        end
    end

endmodule : aftab_branch_cond_decode
`default_nettype wire

// File: rtl/aftab_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : aftab_branch_resolver
// Description : Multi-cycle branch / SLT resolver. Latches the operation on
//               start, samples the comparator flags one cycle later, then
//               registers the branch decision/target or SLT result and
//               pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module aftab_branch_resolver
    import aftab_branch_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic            isBranch_i,
    input  logic [2:0]      funct3_i,
    input  logic [SIZE-1:0] pc_i,
    input  logic [SIZE-1:0] imm_i,
    input  logic            lt_i,
    input  logic            eq_i,
    input  logic            gt_i,
    output logic            comparedSignedUnsignedBar_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            branchTaken_o,
    output logic [SIZE-1:0] branchTarget_o,
    output logic            misaligned_o,
    output logic [SIZE-1:0] sltResult_o,
    output logic            illegal_o
);

    state_t          state_q, state_d;

    logic            isBranch_q;
    logic [2:0]      funct3_q;
    logic [SIZE-1:0] pc_q;
    logic [SIZE-1:0] imm_q;
    logic            lt_q, eq_q, gt_q;

    logic            done_q;
    logic            taken_q;
    logic [SIZE-1:0] target_q;
    logic            mis_q;
    logic [SIZE-1:0] slt_q;
    logic            illegal_q;

    logic            w_accept;
    logic            w_taken;
    logic            w_slt_bit;
    logic            w_illegal;
    logic            w_signed;
    logic [SIZE-1:0] w_sum;

    // A request is taken only from IDLE, and flush always has priority
    assign w_accept = (state_q == IDLE) && start_i && !flush_i;

    // Target adder: wraps silently modulo 2^SIZE
    assign w_sum = pc_q + imm_q;

    aftab_branch_cond_decode u_cond_decode (
        .isBranch_i (isBranch_q),
        .funct3_i   (funct3_q),
        .lt_i       (lt_q),
        .eq_i       (eq_q),
        .gt_i       (gt_q),
        .taken_o    (w_taken),
        .sltBit_o   (w_slt_bit),
        .illegal_o  (w_illegal),
        .signed_o   (w_signed)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> CAPTURE -> RESOLVE -> IDLE, flush aborts
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = CAPTURE;
                CAPTURE: state_d = RESOLVE;
                RESOLVE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Operation latch on accept; comparator flags sampled at end of CAPTURE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isBranch_q <= 1'b0;
            funct3_q   <= 3'b000;
            pc_q       <= '0;
            imm_q      <= '0;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
            gt_q       <= 1'b0;
        end else begin
            if (w_accept) begin
                isBranch_q <= isBranch_i;
                funct3_q   <= funct3_i;
                pc_q       <= pc_i;
                imm_q      <= imm_i;
            end
            if ((state_q == CAPTURE) && !flush_i) begin
                lt_q <= lt_i;
                eq_q <= eq_i;
                gt_q <= gt_i;
            end
        end
    end

    // Result registers update only on a completed RESOLVE and hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            target_q  <= '0;
            mis_q     <= 1'b0;
            slt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            done_q <= (state_q == RESOLVE) && !flush_i;
            if ((state_q == RESOLVE) && !flush_i) begin
                taken_q   <= w_taken;
                target_q  <= isBranch_q ? w_sum : '0;
                mis_q     <= w_taken && (w_sum[1:0] != 2'b00);
                slt_q     <= {{(SIZE-1){1'b0}}, w_slt_bit};
                illegal_q <= w_illegal;
            end
        end
    end

    assign comparedSignedUnsignedBar_o = w_signed;
    assign busy_o                      = (state_q != IDLE);
    assign done_o                      = done_q;
    assign branchTaken_o               = taken_q;
    assign branchTarget_o              = target_q;
    assign misaligned_o                = mis_q;
    assign sltResult_o                 = slt_q;
    assign illegal_o                   = illegal_q;

endmodule : aftab_branch_resolver
`default_nettype wire

// File: tb/tb_aftab_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_aftab_branch_resolver
// Description : Self-checking bench for aftab_branch_resolver. The bench acts
//               as the datapath comparator and predicts results directly from
//               RV32I branch/SLT semantics on the operand values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aftab_branch_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, flush_i, isBranch_i;
    logic [2:0]  funct3_i;
    logic [31:0] pc_i, imm_i;
    logic        lt_i, eq_i, gt_i;
    logic        sign_o, busy_o, done_o, taken_o, mis_o, ill_o;
    logic [31:0] target_o, slt_o;

    logic [31:0] opA, opB;
    int          checks   = 0;
    int          failures = 0;

    typedef struct packed {
        logic        sign;
        logic        taken;
        logic [31:0] target;
        logic        mis;
        logic [31:0] slt;
        logic        ill;
    } exp_t;

    exp_t last_exp;

    always #5 clk = ~clk;

    aftab_branch_resolver #(.SIZE(32)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .start_i                     (start_i),
        .flush_i                     (flush_i),
        .isBranch_i                  (isBranch_i),
        .funct3_i                    (funct3_i),
        .pc_i                        (pc_i),
        .imm_i                       (imm_i),
        .lt_i                        (lt_i),
        .eq_i                        (eq_i),
        .gt_i                        (gt_i),
        .comparedSignedUnsignedBar_o (sign_o),
        .busy_o                      (busy_o),
        .done_o                      (done_o),
        .branchTaken_o               (taken_o),
        .branchTarget_o              (target_o),
        .misaligned_o                (mis_o),
        .sltResult_o                 (slt_o),
        .illegal_o                   (ill_o)
    );

    // Datapath comparator model driven by the DUT's signedness select
    always_comb begin
        if (sign_o) begin
            lt_i = $signed(opA) < $signed(opB);
            gt_i = $signed(opA) > $signed(opB);
        end else begin
            lt_i = opA < opB;
            gt_i = opA > opB;
        end
        eq_i = (opA == opB);
    end

    // Reference: RV32I semantics applied to the raw operands
    function automatic exp_t model(input logic ib, input logic [2:0] f3,
                                   input logic [31:0] pc, imm, a, b);
        exp_t e;
        logic s_lt, u_lt;
        s_lt = $signed(a) < $signed(b);
        u_lt = a < b;
        e = '0;
        e.sign = !(f3 == 3'd6 || f3 == 3'd7 || f3 == 3'd3);
        if (ib) begin
            e.target = pc + imm;
            case (f3)
                3'd0: e.taken = (a == b);
                3'd1: e.taken = (a != b);
                3'd4: e.taken = s_lt;
                3'd5: e.taken = !s_lt;
                3'd6: e.taken = u_lt;
                3'd7: e.taken = !u_lt;
                default: e.ill = 1'b1;
            endcase
            e.mis = e.taken && (e.target[1:0] != 2'b00);
        end else begin
            case (f3)
                3'd2: e.slt = {31'b0, s_lt};
                3'd3: e.slt = {31'b0, u_lt};
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    // Issue one operation, check CAPTURE-phase outputs, latency and results
    task automatic run_op(input logic ib, input logic [2:0] f3,
                          input logic [31:0] pc, imm, a, b, input string tag);
        exp_t e;
        int   n;
        e = model(ib, f3, pc, imm, a, b);
        opA = a; opB = b; isBranch_i = ib; funct3_i = f3;
        pc_i = pc; imm_i = imm; start_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL %s capture busy/done: got %b/%b want 1/0", tag, busy_o, done_o);
        end
        checks++;
        if (sign_o !== e.sign) begin
            failures++;
            $display("FAIL %s signedness: got %b want %b", tag, sign_o, e.sign);
        end
        n = 0;
        do begin
            @(posedge clk); @(negedge clk);
            n++;
            if (n == 1) begin
                checks++;
                if (busy_o !== 1'b1 || done_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s resolve busy/done: got %b/%b want 1/0", tag, busy_o, done_o);
                end
            end
        end while (done_o !== 1'b1 && n < 6);
        checks++;
        if (done_o !== 1'b1 || n != 2) begin
            failures++;
            $display("FAIL %s done latency: got %0d edges (done=%b) want 2", tag, n, done_o);
        end
        if (done_o === 1'b1) begin
            checks++;
            if (busy_o !== 1'b0) begin
                failures++;
                $display("FAIL %s busy at done: got %b want 0", tag, busy_o);
            end
            checks++;
            if ({taken_o, mis_o, ill_o, slt_o} !== {e.taken, e.mis, e.ill, e.slt}) begin
                failures++;
                $display("FAIL %s taken/mis/ill/slt: got %b/%b/%b/%h want %b/%b/%b/%h",
                         tag, taken_o, mis_o, ill_o, slt_o, e.taken, e.mis, e.ill, e.slt);
            end
            if (!e.ill) begin
                checks++;
                if (target_o !== e.target) begin
                    failures++;
                    $display("FAIL %s target: got %h want %h", tag, target_o, e.target);
                end
            end
        end
        last_exp = e;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; isBranch_i = 1'b0;
        funct3_i = 3'd0; pc_i = '0; imm_i = '0; opA = '0; opB = '0;
        #1;
        checks++;
        if ({busy_o, done_o, taken_o, mis_o, ill_o, target_o, slt_o, sign_o} !== {71'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset outputs: busy=%b done=%b taken=%b mis=%b ill=%b tgt=%h slt=%h sign=%b",
                     busy_o, done_o, taken_o, mis_o, ill_o, target_o, slt_o, sign_o);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(1'b1, 3'd0, 32'h100, 32'h20, 32'd7, 32'd7, "beq_taken");
        run_op(1'b1, 3'd6, 32'h200, 32'h8, 32'd1, 32'hFFFF_FFFF, "bltu_taken");
        run_op(1'b1, 3'd5, 32'h300, 32'h44, 32'hFFFF_FFF0, 32'd5, "bge_not_taken");
        run_op(1'b0, 3'd3, 32'h400, 32'h4, 32'd3, 32'd9, "sltu_one");
        run_op(1'b0, 3'd2, 32'h400, 32'h4, 32'hFFFF_FFFF, 32'd9, "slt_neg");
        run_op(1'b1, 3'd2, 32'h500, 32'h4, 32'd1, 32'd2, "illegal_branch");
        run_op(1'b0, 3'd5, 32'h500, 32'h4, 32'd1, 32'd2, "illegal_slt");
        run_op(1'b1, 3'd1, 32'hFFFF_FFF0, 32'h12, 32'd1, 32'd2, "wrap_misaligned");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom, $urandom, a, b, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 3'd4, 32'h1000, 32'h10, 32'hFFFF_FFFE, 32'd1, "b2b_first");
        run_op(1'b1, 3'd7, 32'h2000, 32'h6, 32'd5, 32'd9, "b2b_second");
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b done pulse width: got %b want 0", done_o);
        end
    endtask

    task automatic test_start_while_busy();
        exp_t e;
        int   dones;
        e = model(1'b1, 3'd1, 32'h3000, 32'h100, 32'd1, 32'd2);
        opA = 32'd1; opB = 32'd2; isBranch_i = 1'b1; funct3_i = 3'd1;
        pc_i = 32'h3000; imm_i = 32'h100; start_i = 1'b1;
        @(posedge clk); @(negedge clk);
        funct3_i = 3'd0; pc_i = 32'h7000; imm_i = 32'h3;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || taken_o !== e.taken || target_o !== e.target) begin
            failures++;
            $display("FAIL busy_start result: done=%b taken=%b tgt=%h want 1/%b/%h",
                     done_o, taken_o, target_o, e.taken, e.target);
        end
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_o === 1'b1 || busy_o === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL busy_start extra activity: got %0d cycles want 0", dones);
        end
        last_exp = e;
    endtask

    task automatic test_flush();
        exp_t saved;
        int   dones;
        run_op(1'b1, 3'd0, 32'h100, 32'h20, 32'd4, 32'd4, "pre_flush");
        saved = last_exp;
        opA = 32'd1; opB = 32'd2; isBranch_i = 1'b0; funct3_i = 3'd3;
        pc_i = 32'h9999; imm_i = 32'h1; start_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0; flush_i = 1'b1;
        @(posedge clk); @(negedge clk);
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush capture busy: got %b want 0", busy_o);
        end
        // flush wins over a simultaneous start in IDLE
        start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush over start busy: got %b want 0", busy_o);
        end
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL flush done count: got %0d want 0", dones);
        end
        checks++;
        if ({taken_o, target_o, mis_o, slt_o, ill_o} !==
            {saved.taken, saved.target, saved.mis, saved.slt, saved.ill}) begin
            failures++;
            $display("FAIL flush results held: got %b/%h/%b/%h/%b want %b/%h/%b/%h/%b",
                     taken_o, target_o, mis_o, slt_o, ill_o,
                     saved.taken, saved.target, saved.mis, saved.slt, saved.ill);
        end
        run_op(1'b1, 3'd4, 32'h40, 32'h40, 32'd1, 32'd2, "post_flush");
    endtask

    task automatic test_async_reset();
        run_op(1'b1, 3'd1, 32'h1000, 32'h41, 32'd1, 32'd2, "pre_reset");
        opA = 32'd3; opB = 32'd8; isBranch_i = 1'b1; funct3_i = 3'd6;
        pc_i = 32'h2000; imm_i = 32'h8; start_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || sign_o !== 1'b0 || taken_o !== 1'b1) begin
            failures++;
            $display("FAIL pre-reset resolve state: busy=%b sign=%b taken=%b want 1/0/1",
                     busy_o, sign_o, taken_o);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy_o, done_o, taken_o, mis_o, ill_o, target_o, slt_o, sign_o} !== {71'b0, 1'b1}) begin
            failures++;
            $display("FAIL async reset outputs: busy=%b done=%b taken=%b mis=%b ill=%b tgt=%h slt=%h sign=%b",
                     busy_o, done_o, taken_o, mis_o, ill_o, target_o, slt_o, sign_o);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b1, 3'd6, 32'h2000, 32'h8, 32'd3, 32'd8, "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_aftab_branch_resolver
`default_nettype wire
